// File: rtl/sdaccel_axilite_ctrl_slave.sv
// sdaccel_axilite_ctrl_slave: AXI4-Lite ap_ctrl register block with user argument registers
module sdaccel_axilite_ctrl_slave #(
    parameter int ADDR_W = 64,
    parameter int NUM_USER_REGS = 8
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    output logic                       ap_start,
    input  logic                       ap_done,
    input  logic                       ap_idle,
    input  logic                       ap_ready,
    output logic                       interrupt,
    output logic [NUM_USER_REGS*32-1:0] user_regs,
    input  logic [ADDR_W-1:0]          s_axi_control_AWADDR,
    input  logic [2:0]                 s_axi_control_AWPROT,
    input  logic                       s_axi_control_AWVALID,
    output logic                       s_axi_control_AWREADY,
    input  logic [31:0]                s_axi_control_WDATA,
    input  logic [3:0]                 s_axi_control_WSTRB,
    input  logic                       s_axi_control_WVALID,
    output logic                       s_axi_control_WREADY,
    output logic                       s_axi_control_BVALID,
    input  logic                       s_axi_control_BREADY,
    output logic [1:0]                 s_axi_control_BRESP,
    input  logic [ADDR_W-1:0]          s_axi_control_ARADDR,
    input  logic [2:0]                 s_axi_control_ARPROT,
    input  logic                       s_axi_control_ARVALID,
    output logic                       s_axi_control_ARREADY,
    output logic                       s_axi_control_RVALID,
    input  logic                       s_axi_control_RREADY,
    output logic [31:0]                s_axi_control_RDATA,
    output logic [1:0]                 s_axi_control_RRESP
);
    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic        wr_hs, rd_hs, wr_ctrl;
    logic [9:0]  wr_idx, rd_idx;
    logic        done_bit, auto_restart, gie;
    logic [1:0]  ier, isr;
    logic [31:0] rd_val;
    logic [31:0] uregs [NUM_USER_REGS];
    logic        unused;
    assign unused = ^{s_axi_control_AWPROT, s_axi_control_ARPROT,
                      s_axi_control_AWADDR[1:0], s_axi_control_ARADDR[1:0],
                      s_axi_control_AWADDR[ADDR_W-1:12], s_axi_control_ARADDR[ADDR_W-1:12]};
    assign wr_idx = s_axi_control_AWADDR[11:2];
    assign rd_idx = s_axi_control_ARADDR[11:2];
    // AW and W are only ever accepted together, in a single joint handshake
    assign wr_hs = (w_state == W_IDLE) && s_axi_control_AWVALID && s_axi_control_WVALID;
    assign wr_ctrl = wr_hs && s_axi_control_WSTRB[0];
    assign s_axi_control_AWREADY = wr_hs;
    assign s_axi_control_WREADY = wr_hs;
    assign s_axi_control_BVALID = (w_state == W_RESP);
    assign s_axi_control_BRESP = 2'b00;
    assign s_axi_control_ARREADY = (r_state == R_IDLE);
    assign rd_hs = s_axi_control_ARREADY && s_axi_control_ARVALID;
    assign s_axi_control_RVALID = (r_state == R_DATA);
    assign s_axi_control_RRESP = 2'b00;
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end
    always_comb begin
        w_next = (w_state == W_IDLE) ? (wr_hs ? W_RESP : W_IDLE)
                                     : (s_axi_control_BREADY ? W_IDLE : W_RESP);
        r_next = (r_state == R_IDLE) ? (rd_hs ? R_DATA : R_IDLE)
                                     : (s_axi_control_RREADY ? R_IDLE : R_DATA);
    end
    always_comb begin
        rd_val = (rd_idx == 10'd0) ? {24'b0, auto_restart, 3'b0, ap_ready, ap_idle, done_bit, ap_start} :
                 (rd_idx == 10'd1) ? {31'b0, gie} :
                 (rd_idx == 10'd2) ? {30'b0, ier} :
                 (rd_idx == 10'd3) ? {30'b0, isr} : 32'b0;
        for (int k = 0; k < NUM_USER_REGS; k++)
            if (rd_idx == 10'(k + 4)) rd_val = uregs[k];
    end
    // Pulses win over clears/toggles, so a coincident event is never lost
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ap_start <= 1'b0;
            auto_restart <= 1'b0;
            done_bit <= 1'b0;
            gie <= 1'b0;
            ier <= 2'b0;
            isr <= 2'b0;
            interrupt <= 1'b0;
            s_axi_control_RDATA <= 32'b0;
        end else begin
            ap_start <= (wr_ctrl && wr_idx == 10'd0 && s_axi_control_WDATA[0]) ||
                        (ap_start && !(ap_ready && !auto_restart));
            auto_restart <= (wr_ctrl && wr_idx == 10'd0) ? s_axi_control_WDATA[7] : auto_restart;
            done_bit <= ap_done || (done_bit && !(rd_hs && rd_idx == 10'd0));
            gie <= (wr_ctrl && wr_idx == 10'd1) ? s_axi_control_WDATA[0] : gie;
            ier <= (wr_ctrl && wr_idx == 10'd2) ? s_axi_control_WDATA[1:0] : ier;
            isr <= (isr ^ ((wr_ctrl && wr_idx == 10'd3) ? s_axi_control_WDATA[1:0] : 2'b0)) |
                   {ap_ready & ier[1], ap_done & ier[0]};
            interrupt <= gie & |isr;
            s_axi_control_RDATA <= rd_hs ? rd_val : s_axi_control_RDATA;
        end
    end
    for (genvar k = 0; k < NUM_USER_REGS; k++) begin : g_user
        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) uregs[k] <= 32'b0;
            else for (int b = 0; b < 4; b++)
                if (wr_hs && s_axi_control_WSTRB[b] && wr_idx == 10'(k + 4))
                    uregs[k][8*b +: 8] <= s_axi_control_WDATA[8*b +: 8];
        end
        assign user_regs[32*k +: 32] = uregs[k];
    end
endmodule
